// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA geometry shared by the frame timer and its helpers.
// All coordinates are 10-bit unsigned; constants are typed to match the counters.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam coord_t H_VISIBLE = 10'd640;
    localparam coord_t H_FP      = 10'd16;
    localparam coord_t H_SYNC    = 10'd96;
    localparam coord_t H_BP      = 10'd48;
    localparam coord_t H_TOTAL   = 10'd800;

    localparam coord_t V_VISIBLE = 10'd480;
    localparam coord_t V_FP      = 10'd10;
    localparam coord_t V_SYNC    = 10'd2;
    localparam coord_t V_BP      = 10'd33;
    localparam coord_t V_TOTAL   = 10'd525;

    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enabled shift register of DEPTH stages with a common reset value.
// DEPTH = 0 degenerates to a wire.
module sync_delay_line #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk_i, rst_i, en_i};
            assign q_o         = d_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
                end else if (en_i) begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_frame_timer.sv
// VGA raster timing plus a frame-synchronous latch for the eight displayed hex nibbles.
// Nibbles only change on the frame_clk cycle, so a frame never shows a torn value.
module vga_frame_timer
    import vga_timing_pkg::*;
#(
    parameter int     CLK_DIV    = 2,
    parameter int     SYNC_DELAY = 1,
    // Vertical geometry is overridable so short rasters can be built; defaults are 480-line VGA.
    parameter coord_t V_ACT      = V_VISIBLE,
    parameter coord_t V_FRONT    = V_FP,
    parameter coord_t V_PULSE    = V_SYNC,
    parameter coord_t V_BACK     = V_BP
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] disp_word,
    input  logic        disp_valid,
    output logic        pixel_ce,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        frame_clk,
    output logic [3:0]  c1,
    output logic [3:0]  c2,
    output logic [3:0]  c3,
    output logic [3:0]  c4,
    output logic [3:0]  c5,
    output logic [3:0]  c6,
    output logic [3:0]  c7,
    output logic [3:0]  c8
);

    localparam int          CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    localparam coord_t H_LAST    = H_TOTAL - 10'd1;
    localparam coord_t H_SYNC_LO = H_VISIBLE + H_FP;
    localparam coord_t H_SYNC_HI = H_SYNC_LO + H_SYNC - 10'd1;
    localparam coord_t V_LINES   = V_ACT + V_FRONT + V_PULSE + V_BACK;
    localparam coord_t V_LAST    = V_LINES - 10'd1;
    localparam coord_t V_ACT_END = V_ACT - 10'd1;
    localparam coord_t V_SYNC_LO = V_ACT + V_FRONT;
    localparam coord_t V_SYNC_HI = V_SYNC_LO + V_PULSE - 10'd1;

    // {HS, VS, BLANK_N} while idle: syncs deasserted, picture blanked.
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    logic [CW-1:0] cnt_q, cnt_d;
    coord_t        x_q, x_d, y_q, y_d;
    logic          frame_q, frame_d;
    logic [31:0]   disp_q, disp_d;
    logic [31:0]   pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic          pix_ce;

    assign pix_ce = !Reset && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d   = pix_ce ? '0 : cnt_q + CW'(1);
        x_d     = x_q;
        y_d     = y_q;
        frame_d = 1'b0;
        if (pix_ce) begin
            if (x_q == H_LAST) begin
                x_d     = '0;
                y_d     = (y_q == V_LAST) ? '0 : y_q + 10'd1;
                frame_d = (y_q == V_ACT_END);
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // A strobe coinciding with frame_clk goes straight to the display and leaves pending idle.
    always_comb begin
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (frame_q) begin
            if (disp_valid) begin
                disp_d = disp_word;
            end else if (pend_vld_q) begin
                disp_d = pend_q;
            end
            pend_vld_d = 1'b0;
        end else if (disp_valid) begin
            pend_d     = disp_word;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            frame_q    <= 1'b0;
            disp_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            frame_q    <= frame_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    logic [2:0] sync_raw, sync_dly;

    assign sync_raw = {!in_range(x_q, H_SYNC_LO, H_SYNC_HI),
                       !in_range(y_q, V_SYNC_LO, V_SYNC_HI),
                       (x_q < H_VISIBLE) && (y_q < V_ACT)};

    sync_delay_line #(
        .DEPTH   (SYNC_DELAY),
        .WIDTH   (3),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk_i (Clk),
        .rst_i (Reset),
        .en_i  (pix_ce),
        .d_i   (sync_raw),
        .q_o   (sync_dly)
    );

    // Gating keeps the idle levels during reset even when the delay line is a wire.
    assign {VGA_HS, VGA_VS, VGA_BLANK_N} = Reset ? SYNC_IDLE : sync_dly;

    assign pixel_ce  = pix_ce;
    assign DrawX     = x_q;
    assign DrawY     = y_q;
    assign frame_clk = frame_q;
    assign {c1, c2, c3, c4, c5, c6, c7, c8} = disp_q;

endmodule

// File: tb/tb_vga_frame_timer.sv
// Directed bench on a shortened 8-line raster (full 800-pixel lines); expected values are hand-derived.
module tb_vga_frame_timer;

    localparam int LINE  = 800;
    localparam int LINES = 8;
    localparam int FRAME = LINE * LINES;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] disp_word;
    logic        disp_valid;
    logic        pixel_ce, VGA_HS, VGA_VS, VGA_BLANK_N, frame_clk;
    logic [9:0]  DrawX, DrawY;
    logic [3:0]  c1, c2, c3, c4, c5, c6, c7, c8;

    vga_frame_timer #(
        .CLK_DIV    (2),
        .SYNC_DELAY (1),
        .V_ACT      (10'd4),
        .V_FRONT    (10'd1),
        .V_PULSE    (10'd2),
        .V_BACK     (10'd1)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .disp_word   (disp_word),
        .disp_valid  (disp_valid),
        .pixel_ce    (pixel_ce),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .frame_clk   (frame_clk),
        .c1 (c1), .c2 (c2), .c3 (c3), .c4 (c4),
        .c5 (c5), .c6 (c6), .c7 (c7), .c8 (c8)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pix_total = 0;
    int pulses = 0;
    int t1, t2, t3;

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (Reset) begin
            pix_total <= 0;
            pulses    <= 0;
        end else begin
            if (pixel_ce)  pix_total <= pix_total + 1;
            if (frame_clk) pulses    <= pulses + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Run until the target pixel count since reset, then confirm the raster position.
    task automatic goto_pix(input int target);
        int guard = 0;
        while (pix_total < target && guard < 40000) begin
            tick();
            guard++;
        end
        chk("reach", pix_total, target);
        chk("drawx", {22'd0, DrawX}, target % LINE);
        chk("drawy", {22'd0, DrawY}, (target / LINE) % LINES);
    endtask

    task automatic strobe(input logic [31:0] w);
        disp_word  = w;
        disp_valid = 1'b1;
        tick();
        disp_valid = 1'b0;
    endtask

    function automatic logic [31:0] nibs();
        return {c1, c2, c3, c4, c5, c6, c7, c8};
    endfunction

    initial begin
        Reset      = 1'b1;
        disp_valid = 1'b0;
        disp_word  = '0;
        repeat (3) tick();
        chk("rst_x",     {22'd0, DrawX}, 0);
        chk("rst_y",     {22'd0, DrawY}, 0);
        chk("rst_ce",    pixel_ce, 0);
        chk("rst_frame", frame_clk, 0);
        chk("rst_sync",  {VGA_HS, VGA_VS, VGA_BLANK_N}, 3'b110);
        chk("rst_nibs",  nibs(), 0);

        Reset = 1'b0;
        chk("ce_clk1", pixel_ce, 0);
        tick();
        chk("ce_clk2", pixel_ce, 1);

        goto_pix(LINE);
        strobe(32'hDEADBEEF);
        chk("hold_dead", nibs(), 0);

        goto_pix(LINE + 656);  chk("hs_656", VGA_HS, 1);
        goto_pix(LINE + 657);  chk("hs_657", VGA_HS, 0);
        goto_pix(LINE + 752);  chk("hs_752", VGA_HS, 0);
        goto_pix(LINE + 753);  chk("hs_753", VGA_HS, 1);

        goto_pix(2 * LINE + 640); chk("blank_640", VGA_BLANK_N, 1);
        goto_pix(2 * LINE + 641); chk("blank_641", VGA_BLANK_N, 0);
        goto_pix(3 * LINE + 1);   chk("blank_l3",  VGA_BLANK_N, 1);

        goto_pix(4 * LINE);
        chk("fclk1", frame_clk, 1);
        chk("pre_load", nibs(), 0);
        t1 = cyc;
        tick();
        chk("fclk1_width", frame_clk, 0);
        chk("load_dead", nibs(), 32'hDEADBEEF);

        goto_pix(4 * LINE + 1); chk("vblank", VGA_BLANK_N, 0);
        goto_pix(5 * LINE);     chk("vs_l5_x0", VGA_VS, 1);
        goto_pix(5 * LINE + 1); chk("vs_l5_x1", VGA_VS, 0);
        goto_pix(7 * LINE);     chk("vs_l7_x0", VGA_VS, 0);
        goto_pix(7 * LINE + 1); chk("vs_l7_x1", VGA_VS, 1);

        strobe(32'h12345678);
        tick();
        strobe(32'h0000ABCD);
        chk("hold_abcd", nibs(), 32'hDEADBEEF);

        goto_pix(FRAME);
        goto_pix(FRAME + 4 * LINE);
        chk("fclk2", frame_clk, 1);
        t2 = cyc;
        chk("fclk_period", t2 - t1, 2 * FRAME);
        tick();
        chk("load_abcd", nibs(), 32'h0000ABCD);

        goto_pix(2 * FRAME + 4 * LINE);
        chk("fclk3", frame_clk, 1);
        t3 = cyc;
        chk("fclk_period2", t3 - t2, 2 * FRAME);
        strobe(32'hCAFEF00D);
        chk("bypass", nibs(), 32'hCAFEF00D);
        chk("pulse_cnt", pulses, 3);

        strobe(32'h11112222);
        goto_pix(2 * FRAME + 6 * LINE + 300);
        chk("pre_rst_vs", VGA_VS, 0);
        Reset = 1'b1;
        tick();
        chk("mid_rst_xy",   {12'd0, DrawY, DrawX}, 0);
        chk("mid_rst_sync", {VGA_HS, VGA_VS, VGA_BLANK_N}, 3'b110);
        chk("mid_rst_nibs", nibs(), 0);
        chk("mid_rst_ce",   pixel_ce, 0);
        Reset = 1'b0;

        goto_pix(4 * LINE);
        chk("fclk_after_rst", frame_clk, 1);
        tick();
        chk("no_stale_load", nibs(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
